// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - register file storage with two registered read ports, bypass and stall refresh
module regfile_read_port #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      wren,
  input  logic [WIDTH-1:0] wrdata,
  input  logic             rd_en,
  input  logic             stall,
  input  logic [4:0]       rdaddr1,
  input  logic [4:0]       rdaddr2,
  output logic [WIDTH-1:0] rddata1,
  output logic [WIDTH-1:0] rddata2,
  output logic             rd_valid,
  output logic             wr_err
);

  localparam logic [4:0] ZADDR = 5'(ZERO_REG);

  logic [WIDTH-1:0] mem [32];
  logic [4:0]       held1;
  logic [4:0]       held2;

  logic             wr_any;
  logic             wr_multi;
  logic             wr_ok;
  logic [4:0]       wr_idx;
  logic [WIDTH-1:0] cap1;
  logic [WIDTH-1:0] cap2;
  logic             ref_hit1;
  logic             ref_hit2;

  // Decode the one-hot write enable into an index and classify it as none / single / multiple.
  always_comb begin
    wr_idx   = 5'd0;
    wr_any   = |wren;
    wr_multi = (wren & (wren - 32'd1)) != 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (wren[i]) wr_idx = 5'(i);
    end
    wr_ok = wr_any && !wr_multi && (wr_idx != ZADDR);
  end

  // Post-write view of the addressed registers: zero register wins, then same-cycle bypass, then storage.
  always_comb begin
    cap1 = mem[rdaddr1];
    cap2 = mem[rdaddr2];
    if (wr_ok && (wr_idx == rdaddr1)) cap1 = wrdata;
    if (wr_ok && (wr_idx == rdaddr2)) cap2 = wrdata;
    if (rdaddr1 == ZADDR) cap1 = '0;
    if (rdaddr2 == ZADDR) cap2 = '0;
    ref_hit1 = rd_valid && wr_ok && (wr_idx == held1);
    ref_hit2 = rd_valid && wr_ok && (wr_idx == held2);
  end

  // Register storage; only a single-bit write to a non-zero register lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_idx] <= wrdata;
    end
  end

  // Multi-bit write enables are flagged one cycle later.
  always_ff @(posedge clk) begin
    if (reset) wr_err <= 1'b0;
    else       wr_err <= wr_multi;
  end

  // Read outputs: stall holds and refreshes held operands, otherwise capture or go idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rddata1  <= '0;
      rddata2  <= '0;
      rd_valid <= 1'b0;
      held1    <= 5'd0;
      held2    <= 5'd0;
    end else if (stall) begin
      if (ref_hit1) rddata1 <= wrdata;
      if (ref_hit2) rddata2 <= wrdata;
    end else if (rd_en) begin
      held1    <= rdaddr1;
      held2    <= rdaddr2;
      rddata1  <= cap1;
      rddata2  <= cap2;
      rd_valid <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_read_port.sv
// tb/tb_regfile_read_port.sv - randomized and directed bench for regfile_read_port
module tb_regfile_read_port;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   wren;
  logic [W-1:0]  wrdata;
  logic          rd_en;
  logic          stall;
  logic [4:0]    rdaddr1;
  logic [4:0]    rdaddr2;
  logic [W-1:0]  rddata1;
  logic [W-1:0]  rddata2;
  logic          rd_valid;
  logic          wr_err;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [W-1:0] m_mem [32];
  logic [W-1:0] e_d1, e_d2;
  logic         e_v, e_err;
  int           h1, h2;

  regfile_read_port #(.WIDTH(W), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .wren(wren), .wrdata(wrdata),
    .rd_en(rd_en), .stall(stall), .rdaddr1(rdaddr1), .rdaddr2(rdaddr2),
    .rddata1(rddata1), .rddata2(rddata2), .rd_valid(rd_valid), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs, advance the model by the spec rules, sample 1ns after the edge
  task automatic step(input logic r, input logic [31:0] we, input logic [W-1:0] wd,
                      input logic re, input logic st, input int a1, input int a2);
    int n;
    int idx;
    reset = r; wren = we; wrdata = wd; rd_en = re; stall = st;
    rdaddr1 = 5'(a1); rdaddr2 = 5'(a2);
    @(posedge clk);
    n = $countones(we);
    idx = -1;
    for (int i = 0; i < 32; i++) if (we[i]) idx = i;
    if (r) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      e_d1 = '0; e_d2 = '0; e_v = 1'b0; e_err = 1'b0; h1 = 0; h2 = 0;
    end else begin
      e_err = (n > 1);
      if (n == 1 && idx != 31) m_mem[idx] = wd;
      if (st) begin
        if (e_v && n == 1 && idx != 31 && idx == h1) e_d1 = m_mem[h1];
        if (e_v && n == 1 && idx != 31 && idx == h2) e_d2 = m_mem[h2];
      end else if (re) begin
        h1 = a1; h2 = a2;
        e_d1 = (a1 == 31) ? '0 : m_mem[a1];
        e_d2 = (a2 == 31) ? '0 : m_mem[a2];
        e_v = 1'b1;
      end else begin
        e_v = 1'b0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    checks++; if ({rddata1, rddata2, rd_valid, wr_err} !== '0) begin
      failures++; $display("FAIL reset_outputs: got d1=%h d2=%h v=%b err=%b want all zero", rddata1, rddata2, rd_valid, wr_err); end
    step(0, 0, 0, 1, 0, 0, 5);
    checks++; if (rddata1 !== 64'd0 || rddata2 !== 64'd0) begin
      failures++; $display("FAIL reset_read: got d1=%h d2=%h want 0 0", rddata1, rddata2); end
    checks++; if (rd_valid !== 1'b1 || wr_err !== 1'b0) begin
      failures++; $display("FAIL reset_read_flags: got v=%b err=%b want 1 0", rd_valid, wr_err); end
  endtask

  task automatic test_write_read();
    step(0, 32'h0000_0008, 64'hDEAD_BEEF_0000_0003, 0, 0, 0, 0);
    checks++; if (rd_valid !== 1'b0) begin
      failures++; $display("FAIL idle_valid: got %b want 0", rd_valid); end
    step(0, 0, 0, 1, 0, 3, 31);
    checks++; if (rddata1 !== 64'hDEAD_BEEF_0000_0003 || rddata2 !== 64'd0) begin
      failures++; $display("FAIL write_read: got d1=%h d2=%h want deadbeef00000003 0", rddata1, rddata2); end
  endtask

  task automatic test_bypass();
    step(0, 32'h1 << 7, 64'd5, 0, 0, 0, 0);
    step(0, 32'h1 << 7, 64'd9, 1, 0, 7, 7);
    checks++; if (rddata1 !== 64'd9 || rddata2 !== 64'd9) begin
      failures++; $display("FAIL bypass: got d1=%0d d2=%0d want 9 9", rddata1, rddata2); end
  endtask

  task automatic test_stall_refresh();
    step(0, 32'h1 << 4, 64'd1, 0, 0, 0, 0);
    step(0, 32'h1 << 6, 64'd2, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 4, 6);
    step(0, 32'h1 << 4, 64'd77, 1, 1, 6, 4);
    checks++; if (rddata1 !== 64'd77 || rddata2 !== 64'd2 || rd_valid !== 1'b1) begin
      failures++; $display("FAIL stall_refresh: got d1=%0d d2=%0d v=%b want 77 2 1", rddata1, rddata2, rd_valid); end
    step(0, 0, 0, 1, 1, 0, 0);
    checks++; if (rddata1 !== 64'd77 || rddata2 !== 64'd2 || rd_valid !== 1'b1) begin
      failures++; $display("FAIL stall_hold: got d1=%0d d2=%0d v=%b want 77 2 1", rddata1, rddata2, rd_valid); end
  endtask

  task automatic test_zero_errors();
    step(0, 32'h1 << 31, '1, 0, 0, 0, 0);
    checks++; if (wr_err !== 1'b0) begin
      failures++; $display("FAIL zero_write_err: got %b want 0", wr_err); end
    step(0, 0, 0, 1, 0, 31, 31);
    checks++; if (rddata1 !== 64'd0 || rddata2 !== 64'd0) begin
      failures++; $display("FAIL zero_read: got d1=%h d2=%h want 0 0", rddata1, rddata2); end
    step(0, 32'h0000_0006, '1, 0, 0, 0, 0);
    checks++; if (wr_err !== 1'b1) begin
      failures++; $display("FAIL multi_err_pulse: got %b want 1", wr_err); end
    step(0, 0, 0, 1, 0, 1, 2);
    checks++; if (wr_err !== 1'b0) begin
      failures++; $display("FAIL multi_err_clear: got %b want 0", wr_err); end
    checks++; if (rddata1 !== 64'd0 || rddata2 !== 64'd0) begin
      failures++; $display("FAIL multi_no_write: got d1=%h d2=%h want 0 0", rddata1, rddata2); end
  endtask

  task automatic test_reset_mid_stall();
    step(0, 32'h1 << 3, 64'd10, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 3, 3);
    checks++; if (rddata1 !== 64'd10) begin
      failures++; $display("FAIL pre_stall_capture: got %0d want 10", rddata1); end
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);
    checks++; if (rddata1 !== 64'd0 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid_stall: got d1=%0d v=%b want 0 0", rddata1, rd_valid); end
    step(0, 0, 0, 1, 0, 3, 3);
    checks++; if (rddata1 !== 64'd0 || rd_valid !== 1'b1) begin
      failures++; $display("FAIL read_after_reset: got d1=%0d v=%b want 0 1", rddata1, rd_valid); end
  endtask

  function automatic int pick_addr();
    return ($urandom_range(0, 9) == 0) ? 31 : int'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [31:0] we;
    logic [W-1:0] wd;
    int k;
    for (int c = 0; c < 400; c++) begin
      k = $urandom_range(0, 9);
      if (k < 3)      we = 32'd0;
      else if (k < 8) we = 32'h1 << pick_addr();
      else            we = $urandom() | (32'h1 << $urandom_range(0, 31)) | 32'h1;
      wd = {$urandom(), $urandom()};
      step(($urandom_range(0, 49) == 0), we, wd, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, pick_addr(), pick_addr());
      checks++; if (rddata1 !== e_d1 || rddata2 !== e_d2) begin
        failures++; $display("FAIL rand_data[%0d]: got d1=%h d2=%h want %h %h", c, rddata1, rddata2, e_d1, e_d2); end
      checks++; if (rd_valid !== e_v || wr_err !== e_err) begin
        failures++; $display("FAIL rand_flags[%0d]: got v=%b err=%b want %b %b", c, rd_valid, wr_err, e_v, e_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    e_d1 = '0; e_d2 = '0; e_v = 1'b0; e_err = 1'b0; h1 = 0; h2 = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_stall_refresh();
    test_zero_errors();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
